// File: rtl/interfaz_tx.sv
// Transmit-side glue between the ALU and the UART TX: queues ALU result bytes
// in a small FIFO and hands them one at a time to the UART with start/done.
//
//  state    | meaning
//  ST_IDLE  | no byte in flight; pops the FIFO head into o_data when non-empty
//  ST_START | o_tx_start high for exactly this cycle
//  ST_WAIT  | UART is sending o_data; leave on i_tx_done
module interfaz_tx #(
    parameter int NB_DATA    = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_resultado,
    input  logic               i_alu_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_full,
    output logic               o_overflow
);

    localparam int                  DEPTH   = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] CNT_MAX = (LOG2_DEPTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT
    } state_t;

    state_t                  state;
    logic [NB_DATA-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr;
    logic [LOG2_DEPTH-1:0]   rd_ptr;
    logic [LOG2_DEPTH:0]     count;
    logic                    push;
    logic                    pop;

    // Fullness is judged on the count before the edge, so a same-cycle pop
    // never makes room for a push into a full FIFO.
    assign push = i_alu_done && (count != CNT_MAX);
    assign pop  = (state == ST_IDLE) && (count != '0);

    assign o_busy = (state != ST_IDLE) || (count != '0);
    assign o_full = (count == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_resultado;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_data     <= '0;
            o_tx_start <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (i_alu_done && (count == CNT_MAX)) begin
                o_overflow <= 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        o_data     <= mem[rd_ptr];
                        rd_ptr     <= rd_ptr + 1'b1;
                        o_tx_start <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interfaz_tx.sv
// Directed bench for interfaz_tx: latency, queueing, overflow, simultaneous
// push/pop, pointer wrap and reset during a transfer.
module tb_interfaz_tx;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_resultado;
    logic       i_alu_done;
    logic       i_tx_done;
    logic [7:0] o_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interfaz_tx #(.NB_DATA(8), .LOG2_DEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_resultado (i_resultado),
        .i_alu_done  (i_alu_done),
        .i_tx_done   (i_tx_done),
        .o_data      (o_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_full      (o_full),
        .o_overflow  (o_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        i_rst      = 1'b0;
        i_alu_done = 1'b0;
        i_tx_done  = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
    endtask

    // Holds for n cycles; o_data must stay put and no new start may appear.
    task automatic hold_check(input string tag, input logic [7:0] exp, input int n);
        logic ok;
        ok = 1'b1;
        repeat (n) begin
            tick();
            if (o_data !== exp || o_tx_start !== 1'b0) ok = 1'b0;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_start(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (o_tx_start !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(o_tx_start), 32'd1);
        chk(tag, 32'(o_data), 32'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"},  32'(o_data),     32'd0);
        chk({tag, "_start"}, 32'(o_tx_start), 32'd0);
        chk({tag, "_busy"},  32'(o_busy),     32'd0);
        chk({tag, "_full"},  32'(o_full),     32'd0);
        chk({tag, "_ovf"},   32'(o_overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q2 [2];
        logic [7:0] b;
        logic       ok;

        i_rst       = 1'b0;
        i_resultado = 8'h00;
        i_alu_done  = 1'b0;
        i_tx_done   = 1'b0;

        // single result
        do_reset();
        check_all_zero("rst");
        i_resultado = 8'h06;
        i_alu_done  = 1'b1;
        tick();
        i_alu_done = 1'b0;
        chk("t1_busy", 32'(o_busy), 32'd1);
        chk("t1_nostart", 32'(o_tx_start), 32'd0);
        tick();
        chk("t1_start", 32'(o_tx_start), 32'd1);
        chk("t1_data", 32'(o_data), 32'h06);
        hold_check("t1_hold", 8'h06, 5);
        pulse_done();
        chk("t1_idle", 32'(o_busy), 32'd0);

        // queueing during a transfer
        i_alu_done  = 1'b1;
        i_resultado = 8'h06;
        tick();
        i_resultado = 8'h03;
        tick();
        chk("t2_start0", 32'(o_tx_start), 32'd1);
        chk("t2_data0", 32'(o_data), 32'h06);
        i_resultado = 8'h22;
        tick();
        i_alu_done = 1'b0;
        hold_check("t2_hold0", 8'h06, 19);
        q2[0] = 8'h03;
        q2[1] = 8'h22;
        for (int i = 0; i < 2; i++) begin
            pulse_done();
            chk("t2_gap", 32'(o_tx_start), 32'd0);
            tick();
            chk("t2_start", 32'(o_tx_start), 32'd1);
            chk("t2_data", 32'(o_data), 32'(q2[i]));
            hold_check("t2_hold", q2[i], 20);
        end
        pulse_done();
        chk("t2_idle", 32'(o_busy), 32'd0);

        // push in the same cycle as the IDLE pop
        i_resultado = 8'h5A;
        i_alu_done  = 1'b1;
        tick();
        i_resultado = 8'hA5;
        tick();
        i_alu_done = 1'b0;
        chk("t3_start", 32'(o_tx_start), 32'd1);
        chk("t3_data", 32'(o_data), 32'h5A);
        chk("t3_count", 32'(dut.count), 32'd1);
        hold_check("t3_hold0", 8'h5A, 3);
        pulse_done();
        tick();
        chk("t3_start1", 32'(o_tx_start), 32'd1);
        chk("t3_data1", 32'(o_data), 32'hA5);
        hold_check("t3_hold1", 8'hA5, 3);
        pulse_done();
        chk("t3_idle", 32'(o_busy), 32'd0);

        // overflow with one byte in flight
        i_resultado = 8'hAA;
        i_alu_done  = 1'b1;
        tick();
        i_alu_done = 1'b0;
        tick();
        chk("t4_first", 32'(o_data), 32'hAA);
        for (int i = 0; i < 5; i++) begin
            i_resultado = 8'h10 + 8'(i);
            i_alu_done  = 1'b1;
            tick();
            if (i == 2) chk("t4_notfull", 32'(o_full), 32'd0);
            if (i == 3) chk("t4_full", 32'(o_full), 32'd1);
            if (i == 3) chk("t4_noovf", 32'(o_overflow), 32'd0);
            if (i == 4) chk("t4_ovf", 32'(o_overflow), 32'd1);
        end
        i_alu_done = 1'b0;
        hold_check("t4_hold", 8'hAA, 3);
        for (int i = 0; i < 4; i++) begin
            pulse_done();
            tick();
            chk("t4_start", 32'(o_tx_start), 32'd1);
            chk("t4_data", 32'(o_data), 32'h10 + 32'(i));
            hold_check("t4_hold", 8'h10 + 8'(i), 2);
        end
        pulse_done();
        hold_check("t4_dropped", 8'h13, 3);
        chk("t4_idle", 32'(o_busy), 32'd0);
        chk("t4_sticky", 32'(o_overflow), 32'd1);

        // ten results through the pointers
        do_reset();
        chk("t5_ovf_clr", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 10; i++) begin
            b = 8'(i * 37 + 1);
            i_resultado = b;
            i_alu_done  = 1'b1;
            tick();
            i_alu_done = 1'b0;
            wait_start("t5_data", b);
            hold_check("t5_hold", b, 2);
            pulse_done();
        end
        chk("t5_ovf", 32'(o_overflow), 32'd0);
        chk("t5_idle", 32'(o_busy), 32'd0);

        // reset while in WAIT with two entries queued
        i_resultado = 8'hC3;
        i_alu_done  = 1'b1;
        tick();
        i_resultado = 8'h3C;
        tick();
        i_resultado = 8'h7E;
        tick();
        i_alu_done = 1'b0;
        chk("t6_busy", 32'(o_busy), 32'd1);
        chk("t6_q2", 32'(dut.count), 32'd2);
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        check_all_zero("t6_rst");
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (o_tx_start !== 1'b0 || o_busy !== 1'b0) ok = 1'b0;
        end
        chk("t6_quiet", 32'(ok), 32'd1);
        i_resultado = 8'h99;
        i_alu_done  = 1'b1;
        tick();
        i_alu_done = 1'b0;
        tick();
        chk("t6_restart", 32'(o_tx_start), 32'd1);
        chk("t6_data", 32'(o_data), 32'h99);
        pulse_done();
        pulse_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
